sseg_disp_scan: RTL
===================

SSEG_DISP_SCAN -- requirements
Module: sseg_disp_scan

Interface
REQ-001 Parameter CNT_MAX, default 25000: CLK cycles per digit slot; legal range 2..2^20.
REQ-002 CLK  input  1  rising-edge system clock; the only clock.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 EN  input  1  scan enable; low blanks the display and freezes scanning.
REQ-005 LD  input  1  load strobe; VALUE, DP_EN and BLANK_LZ are sampled when LD=1.
REQ-006 VALUE  input  16  four hex digits; digit i = VALUE[4i+3:4i]; digit 0 is rightmost.
REQ-007 DP_EN  input  4  decimal point enable per digit, bit i -> digit i.
REQ-008 BLANK_LZ  input  1  leading-zero blanking enable.
REQ-009 AN  output  4  anode drive, one-cold: AN[i]=0 selects digit i.
REQ-010 SEGS  output  8  cathodes, active low: {dp,g,f,e,d,c,b,a}.
REQ-011 FRAME_DONE  output  1  one-cycle pulse when a 4-digit frame completes.

Function
REQ-012 Prescaler: counts 0..CNT_MAX-1 while EN=1, then wraps to 0. TICK is true when the count equals CNT_MAX-1 and EN=1.
REQ-013 Digit index IDX (2 bits): advances 0->1->2->3->0 on TICK; holds otherwise.
REQ-014 AN and SEGS are registered and reflect the IDX value of the previous cycle (1-cycle latency).
REQ-015 AN decode: IDX 0->1110, 1->1101, 2->1011, 3->0111.
REQ-016 Double buffering: LD=1 writes VALUE/DP_EN/BLANK_LZ into a pending register and sets PEND.
REQ-017 Display register update: occurs only on TICK with IDX=3 (frame wrap). If PEND=1, copy pending into display and clear PEND. Display content never changes mid-frame.
REQ-018 Simultaneous LD and frame wrap: the inputs sampled that cycle go directly into the display register, and PEND is cleared.
REQ-019 LD while PEND=1 overwrites pending; last load before the wrap wins.
REQ-020 FRAME_DONE=1 for exactly one cycle, in the cycle after TICK with IDX=3.
REQ-021 Segment map, SEGS[6:0] active low, hex 0-F: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 SEGS[7] (dp) = ~DP_EN[IDX] of the display register.
REQ-023 Leading-zero blanking: when display BLANK_LZ=1, digit i (i=1..3) is blanked (SEGS[6:0]=1111111) if every digit j>=i is 0. Digit 0 is never blanked. The dp is unaffected by blanking.
REQ-024 EN=0: prescaler and IDX hold; next cycle AN=1111 and SEGS=11111111; no FRAME_DONE; LD still accepted.
REQ-025 EN 0->1: scanning resumes from the held prescaler and IDX values; AN shows the held IDX on the next cycle.

Reset
REQ-026 RST=1 at a CLK edge: prescaler=0, IDX=0, PEND=0, pending and display registers cleared (VALUE=0, DP_EN=0, BLANK_LZ=0), AN=1111, SEGS=11111111, FRAME_DONE=0.
REQ-027 Reset has priority over EN, LD and TICK. Reset mid-frame discards any pending load.
REQ-028 First cycle after RST deasserts with EN=1: AN=1110, SEGS=11000000 (digit 0 = "0", dp off).

Verification (CNT_MAX=4)
REQ-029 Scan order: reset, EN=1, LD VALUE=0x1234 held through one wrap. Next frame: AN 1110/1101/1011/0111 for 4 cycles each, SEGS[6:0] = 0011001/0110000/0100100/1111001; FRAME_DONE pulses every 16 cycles.
REQ-030 Tear-free load: with 0x1234 displayed, LD VALUE=0xABCD at IDX=1. Digits 2 and 3 still show 3 and 1; the next frame shows D,C,b,A.
REQ-031 Simultaneous event and overwrite: LD 0x1111 then LD 0x2222 before the wrap -> next frame shows 2222. LD 0x5555 on the wrap cycle -> that frame shows 5555 and PEND=0.
REQ-032 Blanking and dp: VALUE=0x0070, BLANK_LZ=1, DP_EN=0001. Digit 3 and digit 2 SEGS=11111111; digit 1 SEGS=11111000; digit 0 SEGS=01000000.
REQ-033 Enable/reset: EN=0 at IDX=2 -> AN=1111 and no FRAME_DONE for 20 cycles; EN=1 resumes at AN=1011. RST mid-frame -> AN=1111 next cycle and blank display after reset.

Source files
------------

// File: rtl/sseg_disp_scan_if.sv
// rtl/sseg_disp_scan_if.sv - control/data bundle between a display host and the scanner
interface sseg_disp_scan_if;
  logic        en;
  logic        ld;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic [3:0]  an;
  logic [7:0]  segs;
  logic        frame_done;

  modport master (
    output en, ld, value, dp_en, blank_lz,
    input  an, segs, frame_done
  );

  modport slave (
    input  en, ld, value, dp_en, blank_lz,
    output an, segs, frame_done
  );
endinterface

// File: rtl/sseg_disp_scan.sv
// rtl/sseg_disp_scan.sv - 4-digit multiplexed 7-segment scanner with tear-free double buffering
module sseg_disp_scan #(
  parameter int CNT_MAX = 25000
) (
  input  logic            clk,
  input  logic            rst,
  sseg_disp_scan_if.slave bus
);
  localparam int CW = $clog2(CNT_MAX);

  logic [CW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   pend_val, disp_val;
  logic [3:0]    pend_dp, disp_dp;
  logic          pend_bl, disp_bl;
  logic          pend;
  logic [3:0]    an_q;
  logic [7:0]    segs_q;
  logic          fd_q;

  logic          tick, wrap, blank;
  logic [3:0]    nib;
  logic [6:0]    seg7;

  assign tick = bus.en && (presc == CW'(CNT_MAX - 1));
  assign wrap = tick && (idx == 2'd3);

  // A digit is a leading zero when it and every digit to its left are zero.
  assign nib   = disp_val[{idx, 2'b00} +: 4];
  assign blank = disp_bl && (idx != 2'd0) && ((disp_val >> {idx, 2'b00}) == 16'd0);

  always_comb begin
    seg7 = 7'b1111111;
    case (nib)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'ha: seg7 = 7'b0001000;
      4'hb: seg7 = 7'b0000011;
      4'hc: seg7 = 7'b1000110;
      4'hd: seg7 = 7'b0100001;
      4'he: seg7 = 7'b0000110;
      4'hf: seg7 = 7'b0001110;
      default: seg7 = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      idx      <= 2'd0;
      pend     <= 1'b0;
      pend_val <= 16'd0;
      pend_dp  <= 4'd0;
      pend_bl  <= 1'b0;
      disp_val <= 16'd0;
      disp_dp  <= 4'd0;
      disp_bl  <= 1'b0;
      an_q     <= 4'b1111;
      segs_q   <= 8'hff;
      fd_q     <= 1'b0;
    end else begin
      if (bus.en) presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx + 2'd1;
      fd_q <= wrap;

      if (bus.en) begin
        an_q   <= ~(4'b0001 << idx);
        segs_q <= {~disp_dp[idx], blank ? 7'b1111111 : seg7};
      end else begin
        an_q   <= 4'b1111;
        segs_q <= 8'hff;
      end

      // A load coinciding with the frame wrap bypasses the pending stage.
      if (bus.ld && wrap) begin
        disp_val <= bus.value;
        disp_dp  <= bus.dp_en;
        disp_bl  <= bus.blank_lz;
        pend     <= 1'b0;
      end else if (bus.ld) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_en;
        pend_bl  <= bus.blank_lz;
        pend     <= 1'b1;
      end else if (wrap && pend) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        disp_bl  <= pend_bl;
        pend     <= 1'b0;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.segs       = segs_q;
  assign bus.frame_done = fd_q;
endmodule
